// File: rtl/mem_access.sv
// MEM stage: forwards ALU writeback and runs req/ack data-memory transactions
// for loads and stores, with big-endian lane alignment and load extension.
module mem_access #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        mem_wd,
    input  logic              mem_wreg,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_op,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_sdata,
    output logic              stallreq,
    output logic              dm_req,
    output logic              dm_we,
    output logic [3:0]        dm_sel,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    input  logic              dm_ack,
    input  logic [31:0]       dm_rdata,
    output logic [4:0]        wb_wd,
    output logic              wb_wreg,
    output logic [31:0]       wb_wdata,
    output logic              addr_err
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned SEL_W  = 4;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e state, state_d;

    logic              is_load, is_store, is_byte, is_half, is_word, is_signed;
    logic              is_mem, misalign;
    logic [1:0]        off;
    logic [SEL_W-1:0]  sel_c;
    logic [DATA_W-1:0] wdata_c;

    // Access kind captured at issue, used to extend read data on ack
    logic       ld_load, ld_byte, ld_half, ld_signed;
    logic [1:0] ld_off;
    logic       ld_load_d, ld_byte_d, ld_half_d, ld_signed_d;
    logic [1:0] ld_off_d;

    logic              dm_req_d, dm_we_d, wb_wreg_d, addr_err_d;
    logic [SEL_W-1:0]  dm_sel_d;
    logic [ADDR_W-1:0] dm_addr_d;
    logic [DATA_W-1:0] dm_wdata_d, wb_wdata_d;
    logic [REG_W-1:0]  wb_wd_d;

    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;
    logic [DATA_W-1:0] load_val;

    // Opcode decode, lane enables and store-data replication
    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_byte   = 1'b0;
        is_half   = 1'b0;
        is_word   = 1'b0;
        is_signed = 1'b0;
        case (mem_op)
            OP_LB:   begin is_load  = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
            OP_LBU:  begin is_load  = 1'b1; is_byte = 1'b1; end
            OP_LH:   begin is_load  = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
            OP_LHU:  begin is_load  = 1'b1; is_half = 1'b1; end
            OP_LW:   begin is_load  = 1'b1; is_word = 1'b1; end
            OP_SB:   begin is_store = 1'b1; is_byte = 1'b1; end
            OP_SH:   begin is_store = 1'b1; is_half = 1'b1; end
            OP_SW:   begin is_store = 1'b1; is_word = 1'b1; end
            default: ;
        endcase
        off      = mem_addr[1:0];
        is_mem   = is_load | is_store;
        misalign = (is_half & off[0]) | (is_word & (off != 2'b00));

        if (is_byte) begin
            sel_c   = 4'b1000 >> off;
            wdata_c = {4{mem_sdata[7:0]}};
        end else if (is_half) begin
            sel_c   = off[1] ? 4'b0011 : 4'b1100;
            wdata_c = {2{mem_sdata[15:0]}};
        end else begin
            sel_c   = 4'b1111;
            wdata_c = mem_sdata;
        end
    end

    // Big-endian lane pick and sign/zero extension of read data
    always_comb begin
        case (ld_off)
            2'd0:    lane_byte = dm_rdata[31:24];
            2'd1:    lane_byte = dm_rdata[23:16];
            2'd2:    lane_byte = dm_rdata[15:8];
            default: lane_byte = dm_rdata[7:0];
        endcase
        lane_half = ld_off[1] ? dm_rdata[15:0] : dm_rdata[31:16];

        if (ld_byte) begin
            load_val = {{24{ld_signed & lane_byte[7]}}, lane_byte};
        end else if (ld_half) begin
            load_val = {{16{ld_signed & lane_half[15]}}, lane_half};
        end else begin
            load_val = dm_rdata;
        end
    end

    // Next-state, next-output and combinational stall request
    always_comb begin
        state_d     = state;
        dm_req_d    = dm_req;
        dm_we_d     = dm_we;
        dm_sel_d    = dm_sel;
        dm_addr_d   = dm_addr;
        dm_wdata_d  = dm_wdata;
        wb_wd_d     = '0;
        wb_wreg_d   = 1'b0;
        wb_wdata_d  = '0;
        addr_err_d  = 1'b0;
        ld_load_d   = ld_load;
        ld_byte_d   = ld_byte;
        ld_half_d   = ld_half;
        ld_signed_d = ld_signed;
        ld_off_d    = ld_off;
        stallreq    = 1'b0;

        case (state)
            IDLE: begin
                dm_req_d = 1'b0;
                if (is_mem && misalign) begin
                    addr_err_d = 1'b1;
                end else if (is_mem) begin
                    stallreq    = 1'b1;
                    dm_req_d    = 1'b1;
                    dm_we_d     = is_store;
                    dm_sel_d    = sel_c;
                    dm_addr_d   = {mem_addr[ADDR_W-1:2], 2'b00};
                    dm_wdata_d  = wdata_c;
                    ld_load_d   = is_load;
                    ld_byte_d   = is_byte;
                    ld_half_d   = is_half;
                    ld_signed_d = is_signed;
                    ld_off_d    = off;
                    state_d     = BUSY;
                end else begin
                    wb_wd_d    = mem_wd;
                    wb_wreg_d  = mem_wreg;
                    wb_wdata_d = mem_wdata;
                end
            end
            BUSY: begin
                if (dm_ack) begin
                    dm_req_d = 1'b0;
                    state_d  = IDLE;
                    if (ld_load) begin
                        wb_wd_d    = mem_wd;
                        wb_wreg_d  = mem_wreg;
                        wb_wdata_d = load_val;
                    end
                end else begin
                    stallreq = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!rst) begin
            stallreq = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            dm_req    <= 1'b0;
            dm_we     <= 1'b0;
            dm_sel    <= '0;
            dm_addr   <= '0;
            dm_wdata  <= '0;
            wb_wd     <= '0;
            wb_wreg   <= 1'b0;
            wb_wdata  <= '0;
            addr_err  <= 1'b0;
            ld_load   <= 1'b0;
            ld_byte   <= 1'b0;
            ld_half   <= 1'b0;
            ld_signed <= 1'b0;
            ld_off    <= '0;
        end else begin
            state     <= state_d;
            dm_req    <= dm_req_d;
            dm_we     <= dm_we_d;
            dm_sel    <= dm_sel_d;
            dm_addr   <= dm_addr_d;
            dm_wdata  <= dm_wdata_d;
            wb_wd     <= wb_wd_d;
            wb_wreg   <= wb_wreg_d;
            wb_wdata  <= wb_wdata_d;
            addr_err  <= addr_err_d;
            ld_load   <= ld_load_d;
            ld_byte   <= ld_byte_d;
            ld_half   <= ld_half_d;
            ld_signed <= ld_signed_d;
            ld_off    <= ld_off_d;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access; the bench acts as pipeline and memory and
// predicts each instruction's bus and writeback effects from access size/offset.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_sdata;
    logic        stallreq;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_sel;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        addr_err;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    mem_access #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_op(mem_op), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
        .stallreq(stallreq),
        .dm_req(dm_req), .dm_we(dm_we), .dm_sel(dm_sel), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Access size in bytes; 0 means no memory access
    function automatic int op_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd6: return 1;
            4'd3, 4'd4, 4'd7: return 2;
            4'd5, 4'd8:       return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic bit op_is_load(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd5);
    endfunction

    function automatic bit op_is_signed(input logic [3:0] op);
        return (op == 4'd1) || (op == 4'd3);
    endfunction

    // Big-endian: an n-byte item at offset off occupies lanes (3-off) down to (4-off-n)
    function automatic logic [3:0] exp_sel(input int n, input int off);
        int unsigned m;
        m = ((32'd1 << n) - 1) << (4 - off - n);
        return 4'(m);
    endfunction

    function automatic logic [31:0] exp_load(input logic [3:0] op, input int off, input logic [31:0] rd);
        int n;
        logic [31:0] mask, v;
        n    = op_size(op);
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        v    = (rd >> (8 * (4 - off - n))) & mask;
        if (op_is_signed(op) && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] exp_store(input int n, input logic [31:0] sd);
        if (n == 1) return {24'd0, sd[7:0]} * 32'h0101_0101;
        if (n == 2) return {16'd0, sd[15:0]} * 32'h0001_0001;
        return sd;
    endfunction

    // Issue one instruction at a negedge; returns at a negedge with the stage advanced
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int dly);
        int n, off, stalls;
        n   = op_size(op);
        off = int'(addr[1:0]);
        mem_op = op; mem_addr = addr; mem_sdata = sdata;
        mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
        dm_rdata = $urandom;
        dm_ack   = 1'($urandom_range(0, 1));
        if (n == 0) begin
            #1 check("none_stall", 32'(stallreq), 32'd0);
            @(negedge clk);
            check("none_wd", 32'(wb_wd), 32'(wd));
            check("none_wreg", 32'(wb_wreg), 32'(wreg));
            check("none_wdata", wb_wdata, wdata);
            check("none_req", 32'(dm_req), 32'd0);
            check("none_err", 32'(addr_err), 32'd0);
        end else if ((off % n) != 0) begin
            #1 check("mis_stall", 32'(stallreq), 32'd0);
            @(negedge clk);
            check("mis_err", 32'(addr_err), 32'd1);
            check("mis_req", 32'(dm_req), 32'd0);
            check("mis_wreg", 32'(wb_wreg), 32'd0);
            check("mis_wd", 32'(wb_wd), 32'd0);
            check("mis_wdata", wb_wdata, 32'd0);
        end else begin
            dm_ack = 1'b0;
            stalls = 0;
            #1 if (stallreq) stalls++;
            @(negedge clk);
            check("iss_req", 32'(dm_req), 32'd1);
            check("iss_we", 32'(dm_we), 32'(!op_is_load(op)));
            check("iss_sel", 32'(dm_sel), 32'(exp_sel(n, off)));
            check("iss_addr", dm_addr, addr & 32'hFFFF_FFFC);
            if (!op_is_load(op)) check("iss_wdata", dm_wdata, exp_store(n, sdata));
            check("iss_wreg", 32'(wb_wreg), 32'd0);
            check("iss_err", 32'(addr_err), 32'd0);
            for (int i = 0; i < dly; i++) begin
                dm_rdata = $urandom;
                #1 if (stallreq) stalls++;
                @(negedge clk);
                check("wait_req", 32'(dm_req), 32'd1);
                check("wait_sel", 32'(dm_sel), 32'(exp_sel(n, off)));
                check("wait_wreg", 32'(wb_wreg), 32'd0);
            end
            dm_ack   = 1'b1;
            dm_rdata = rdata;
            #1 check("ack_stall", 32'(stallreq), 32'd0);
            check("stall_cycles", 32'(stalls), 32'(dly + 1));
            @(negedge clk);
            dm_ack = 1'b0;
            check("done_req", 32'(dm_req), 32'd0);
            if (op_is_load(op)) begin
                check("ld_wd", 32'(wb_wd), 32'(wd));
                check("ld_wreg", 32'(wb_wreg), 32'(wreg));
                check("ld_wdata", wb_wdata, exp_load(op, off, rdata));
            end else begin
                check("st_wreg", 32'(wb_wreg), 32'd0);
            end
        end
    endtask

    initial begin
        int n;
        logic [3:0]  r_op;
        logic [31:0] r_addr;

        rst = 1'b0;
        mem_op = '0; mem_addr = '0; mem_sdata = '0;
        mem_wd = '0; mem_wreg = 1'b0; mem_wdata = '0;
        dm_ack = 1'b0; dm_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_req", 32'(dm_req), 32'd0);
        check("rst_stall", 32'(stallreq), 32'd0);
        check("rst_wreg", 32'(wb_wreg), 32'd0);
        check("rst_wdata", wb_wdata, 32'd0);
        check("rst_err", 32'(addr_err), 32'd0);
        rst = 1'b1;

        run_op(4'd0, 32'h0,    32'h0,        5'd5, 1'b1, 32'h1234, 32'h0,        0);
        run_op(4'd1, 32'h1001, 32'h0,        5'd3, 1'b1, 32'h0,    32'h11F32233, 3);
        run_op(4'd2, 32'h1001, 32'h0,        5'd4, 1'b1, 32'h0,    32'h11F32233, 3);
        run_op(4'd7, 32'h2002, 32'hAAAABEEF, 5'd0, 1'b0, 32'h0,    32'h0,        0);
        run_op(4'd5, 32'h3001, 32'h0,        5'd6, 1'b1, 32'h0,    32'h0,        0);
        run_op(4'd0, 32'h0,    32'h0,        5'd1, 1'b0, 32'h0,    32'h0,        0);

        // Reset while a load is outstanding
        mem_op = 4'd5; mem_addr = 32'h5000; mem_wd = 5'd9; mem_wreg = 1'b1; dm_ack = 1'b0;
        @(negedge clk);
        check("rb_req", 32'(dm_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("ra_req", 32'(dm_req), 32'd0);
        check("ra_stall", 32'(stallreq), 32'd0);
        check("ra_wreg", 32'(wb_wreg), 32'd0);
        check("ra_wd", 32'(wb_wd), 32'd0);
        check("ra_wdata", wb_wdata, 32'd0);
        @(negedge clk);
        mem_op = 4'd0; mem_wreg = 1'b0; dm_ack = 1'b1; rst = 1'b1;
        @(negedge clk);
        check("rr_wreg", 32'(wb_wreg), 32'd0);
        check("rr_req", 32'(dm_req), 32'd0);
        dm_ack = 1'b0;

        run_op(4'd3, 32'h4000, 32'h0, 5'd10, 1'b1, 32'h0, 32'h80017FFF, 0);
        run_op(4'd4, 32'h4002, 32'h0, 5'd11, 1'b1, 32'h0, 32'h80017FFF, 0);

        for (int k = 0; k < 400; k++) begin
            r_op   = 4'($urandom_range(0, 15));
            r_addr = $urandom;
            n      = op_size(r_op);
            if (n > 0 && $urandom_range(0, 2) != 0) r_addr = r_addr & ~(32'(n) - 32'd1);
            run_op(r_op, r_addr, $urandom, 5'($urandom), 1'($urandom), $urandom,
                   $urandom, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
